// File: rtl/snn_pkg.sv
// snn_pkg: shared image geometry and loader state encoding for the SNN input path.
package snn_pkg;
    localparam int IMG_BITS  = 784;
    localparam int IMG_BYTES = 98;
    typedef enum logic [1:0] {RX, UNPACK, START, WAIT_CORE} state_e;
endpackage

// File: rtl/ram.sv
// ram: single-port synchronous RAM with registered read; read data clears on reset.
module ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= d;
        q <= rst_n ? mem[addr] : '0;
    end
endmodule

// File: rtl/snn_input_loader.sv
// snn_input_loader: unpacks received image bytes into a 1-bit pixel RAM, then hands
// the image to snn_core and waits for it to finish before accepting the next image.
module snn_input_loader
    import snn_pkg::*;
#(
    parameter int IMG_BITS  = snn_pkg::IMG_BITS,
    parameter int IMG_BYTES = snn_pkg::IMG_BYTES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_rdy,
    input  logic [7:0] rx_data,
    input  logic [9:0] addr_input_unit,
    input  logic       core_done,
    output logic       q_input,
    output logic       start,
    output logic       busy,
    output logic       ovr
);
    localparam int BW = $clog2(IMG_BYTES + 1);
    state_e        state_q, state_d;
    logic [7:0]    sr_q, sr_d;
    logic [2:0]    bit_q, bit_d;
    logic [9:0]    wr_addr_q, wr_addr_d;
    logic [BW-1:0] byte_q, byte_d, byte_inc;
    logic          ovr_q, ovr_d;
    logic          we;
    logic [9:0]    ram_addr;
    assign byte_inc = byte_q + 1'b1;
    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        bit_d     = bit_q;
        wr_addr_d = wr_addr_q;
        byte_d    = byte_q;
        ovr_d     = ovr_q;
        we        = 1'b0;
        case (state_q)
            RX: if (rx_rdy) begin
                sr_d    = rx_data;
                bit_d   = '0;
                state_d = UNPACK;
                ovr_d   = (byte_q == '0) ? 1'b0 : ovr_q;
            end
            UNPACK: begin
                we        = 1'b1;
                sr_d      = sr_q >> 1;
                bit_d     = bit_q + 1'b1;
                // saturate so the last pixel write never pushes the pointer past the image
                wr_addr_d = (wr_addr_q == 10'(IMG_BITS - 1)) ? wr_addr_q : wr_addr_q + 1'b1;
                if (bit_q == 3'd7) begin
                    byte_d  = byte_inc;
                    state_d = (byte_inc == BW'(IMG_BYTES)) ? START : RX;
                end
            end
            START: state_d = WAIT_CORE;
            WAIT_CORE: if (core_done) begin
                state_d   = RX;
                wr_addr_d = '0;
                byte_d    = '0;
            end
            default: state_d = RX;
        endcase
        if (rx_rdy && state_q != RX) ovr_d = 1'b1;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= RX;
            sr_q      <= '0;
            bit_q     <= '0;
            wr_addr_q <= '0;
            byte_q    <= '0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bit_q     <= bit_d;
            wr_addr_q <= wr_addr_d;
            byte_q    <= byte_d;
            ovr_q     <= ovr_d;
        end
    end
    assign ram_addr = (state_q == UNPACK) ? wr_addr_q : addr_input_unit;
    assign start    = (state_q == START);
    assign busy     = (state_q != RX);
    assign ovr      = ovr_q;
    ram #(.DATA_WIDTH(1), .ADDR_WIDTH(10)) u_ram (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (we),
        .addr (ram_addr),
        .d    (sr_q[0]),
        .q    (q_input)
    );
endmodule

// File: tb/tb_snn_input_loader.sv
// tb_snn_input_loader: directed checks of image loading, start latency, overrun and reset.
module tb_snn_input_loader;
    logic       clk = 1'b0, rst_n = 1'b0, rx_rdy = 1'b0, core_done = 1'b0;
    logic [7:0] rx_data = '0;
    logic [9:0] addr_input_unit = '0;
    logic       q_input, start, busy, ovr;
    int         tests = 0, fails = 0, start_cnt = 0;
    logic [7:0] img [98];
    typedef struct {logic [9:0] addr; logic exp;} rd_vec_t;
    rd_vec_t    vt [12];

    snn_input_loader dut (
        .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data),
        .addr_input_unit(addr_input_unit), .core_done(core_done),
        .q_input(q_input), .start(start), .busy(busy), .ovr(ovr)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (start) start_cnt++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk); rx_rdy = 1'b1; rx_data = b;
        @(negedge clk); rx_rdy = 1'b0;
    endtask

    task automatic drop();
        @(negedge clk); rx_rdy = 1'b1; rx_data = 8'hEE;
        @(negedge clk); rx_rdy = 1'b0;
    endtask

    task automatic pulse_done();
        @(negedge clk); core_done = 1'b1;
        @(negedge clk); core_done = 1'b0;
    endtask

    // last byte accepted at edge N: start must be high exactly in the cycle ending at edge N+9
    task automatic send_bytes(input int first, input int n, input int gap, input int last);
        int s0;
        s0 = start_cnt;
        for (int i = 0; i < n; i++) begin
            send_byte(img[first + i]);
            if (i < n - 1 || last == 0) idle(gap);
        end
        if (last != 0) begin
            idle(7); check("start_early", start, 0);
            idle(1); check("start_latency", start, 1);
            idle(1); check("start_one_cycle", start, 0);
            check("busy_wait_core", busy, 1);
        end
        check("start_count", start_cnt - s0, last);
    endtask

    task automatic read_bit(input logic [9:0] a, output logic v);
        @(negedge clk); addr_input_unit = a;
        @(negedge clk); v = q_input;
    endtask

    task automatic read_all(input string name);
        int bad;
        bad = 0;
        for (int a = 0; a < 784; a++) begin
            @(negedge clk); addr_input_unit = 10'(a);
            @(negedge clk); if (q_input !== img[a / 8][a % 8]) bad++;
        end
        check(name, bad, 0);
    endtask

    initial begin
        logic v;
        vt[0]  = '{10'd0,   1'b1}; vt[1]  = '{10'd1,   1'b0};
        vt[2]  = '{10'd2,   1'b1}; vt[3]  = '{10'd3,   1'b0};
        vt[4]  = '{10'd4,   1'b0}; vt[5]  = '{10'd5,   1'b1};
        vt[6]  = '{10'd6,   1'b0}; vt[7]  = '{10'd7,   1'b1};
        vt[8]  = '{10'd8,   1'b0}; vt[9]  = '{10'd9,   1'b0};
        vt[10] = '{10'd100, 1'b0}; vt[11] = '{10'd783, 1'b0};

        idle(3);
        check("rst_start", start, 0); check("rst_busy", busy, 0);
        check("rst_ovr", ovr, 0);     check("rst_q", q_input, 0);
        rst_n = 1'b1;

        // all-ones image at 20-cycle spacing
        for (int i = 0; i < 98; i++) img[i] = 8'hFF;
        send_bytes(0, 98, 18, 1);
        read_all("read_all_ones");
        pulse_done();
        check("busy_after_done", busy, 0);

        // single 0xA5 byte then zeros: LSB-first bit order
        for (int i = 0; i < 98; i++) img[i] = 8'h00;
        img[0] = 8'hA5;
        send_bytes(0, 98, 8, 1);
        for (int k = 0; k < 12; k++) begin
            read_bit(vt[k].addr, v);
            check($sformatf("read_a5_addr%0d", vt[k].addr), v, vt[k].exp);
        end
        pulse_done();

        // byte dropped during unpack: still needs 97 more accepted bytes
        for (int i = 0; i < 98; i++) img[i] = 8'h00;
        send_byte(img[0]);
        drop();
        check("ovr_drop_unpack", ovr, 1);
        check("busy_unpack", busy, 1);
        idle(6);
        check("busy_back_rx", busy, 0);
        send_bytes(1, 96, 8, 0);
        check("ovr_sticky_mid", ovr, 1);
        send_bytes(97, 1, 8, 1);
        pulse_done();
        check("busy_after_done2", busy, 0);
        check("ovr_sticky_idle", ovr, 1);

        // first byte of next image clears ovr; then a drop in WAIT_CORE
        img[0] = 8'h5A;
        send_byte(img[0]);
        check("ovr_clear", ovr, 0);
        idle(8);
        send_bytes(1, 97, 8, 1);
        drop();
        check("ovr_drop_wait", ovr, 1);
        check("busy_still_wait", busy, 1);
        pulse_done();
        check("busy_fall_done", busy, 0);
        read_bit(10'd1, v); check("prev_img_addr1", v, 1);

        // next image must start at address 0
        img[0] = 8'h03;
        send_bytes(0, 98, 8, 1);
        read_bit(10'd0, v); check("reload_addr0", v, 1);
        read_bit(10'd1, v); check("reload_addr1", v, 1);
        read_bit(10'd2, v); check("reload_addr2", v, 0);
        read_bit(10'd8, v); check("reload_addr8", v, 0);
        pulse_done();

        // reset during unpack of byte 50 discards the partial image
        for (int i = 0; i < 98; i++) img[i] = 8'(i * 37 + 5);
        send_bytes(0, 50, 8, 0);
        send_byte(img[50]);
        drop();
        check("ovr_before_rst", ovr, 1);
        rst_n = 1'b0;
        idle(1);
        check("mid_rst_start", start, 0); check("mid_rst_busy", busy, 0);
        check("mid_rst_ovr", ovr, 0);     check("mid_rst_q", q_input, 0);
        rst_n = 1'b1;
        send_bytes(0, 97, 8, 0);
        send_bytes(97, 1, 8, 1);
        read_all("read_all_after_rst");
        pulse_done();

        // core_done outside WAIT_CORE is ignored
        pulse_done();
        check("done_in_rx_busy", busy, 0);
        check("done_in_rx_start", start, 0);
        send_byte(8'h01);
        pulse_done();
        check("done_in_unpack_busy", busy, 1);
        idle(6);
        check("unpack_end_busy", busy, 0);
        check("no_stray_start", start_cnt, 6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
